// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and in-order instruction queue feeding decode, with redirect/flush and misaligned-target fault marker
module fetch_unit #(
  parameter int XLen = 32,
  parameter logic [XLen-1:0] ResetVector = '0,
  parameter int QueueDepth = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [XLen-1:0] mem_addr_o,
  input  logic [31:0]     mem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLen-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLen-1:0] instr_pc_o,
  output logic            instr_fault_o
);
  localparam int AW = $clog2(QueueDepth);
  localparam int CW = AW + 1;
  logic [XLen-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     ins_q [QueueDepth];
  logic [XLen-1:0] pcs_q [QueueDepth];
  logic            flt_q [QueueDepth];
  logic            pop, push, misal, we, w_flt;
  logic [XLen-1:0] w_pc;
  logic [31:0]     w_ins;
  assign mem_addr_o    = pc_q;
  assign instr_valid_o = cnt_q != '0;
  assign instr_o       = ins_q[rd_q];
  assign instr_pc_o    = pcs_q[rd_q];
  assign instr_fault_o = flt_q[rd_q];
  // next state: redirect flushes and may enqueue a fault marker; otherwise fetch while there is room
  always_comb begin
    pop      = instr_valid_o & instr_ready_i;
    misal    = |redirect_pc_i[1:0];
    push     = ~redirect_i & ~halted_q & ((cnt_q < CW'(QueueDepth)) | pop);
    we       = redirect_i ? misal : push;
    w_pc     = redirect_i ? redirect_pc_i : pc_q;
    w_ins    = redirect_i ? 32'h0 : mem_rdata_i;
    w_flt    = redirect_i;
    wr_d     = wr_q + AW'(we);
    rd_d     = redirect_i ? wr_q : rd_q + AW'(pop);
    cnt_d    = redirect_i ? CW'(misal) : cnt_q + CW'(push) - CW'(pop);
    pc_d     = redirect_i ? redirect_pc_i : (push ? pc_q + XLen'(4) : pc_q);
    halted_d = redirect_i ? misal : halted_q;
  end
  // state and queue storage; reset clears everything including storage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q     <= ResetVector;
      halted_q <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < QueueDepth; i++) begin
        ins_q[i] <= '0;
        pcs_q[i] <= '0;
        flt_q[i] <= 1'b0;
      end
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      if (we) begin
        ins_q[wr_q] <= w_ins;
        pcs_q[wr_q] <= w_pc;
        flt_q[wr_q] <= w_flt;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit against an XOR-pattern instruction memory
module tb_fetch_unit;
  localparam logic [31:0] RV = 32'h0000_1000;
  localparam logic [31:0] PAT = 32'hA5A5_A5A5;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        f;
  } ent_t;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] mem_addr_o, mem_rdata_i, redirect_pc_i, instr_o, instr_pc_o;
  logic        redirect_i, instr_valid_o, instr_ready_i, instr_fault_o;
  ent_t        exp_q[$];
  int          total = 0, bad = 0, pops = 0, p0;
  fetch_unit #(.XLen(32), .ResetVector(RV), .QueueDepth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_fault_o(instr_fault_o)
  );
  always #5 clk_i = ~clk_i;
  assign mem_rdata_i = mem_addr_o ^ PAT;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  task automatic push_stream(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back('{pc: pc + 32'(4 * i), ins: (pc + 32'(4 * i)) ^ PAT, f: 1'b0});
  endtask
  task automatic push_fault(input logic [31:0] pc);
    exp_q.delete();
    exp_q.push_back('{pc: pc, ins: 32'h0, f: 1'b1});
  endtask
  // scoreboard: compare every handshake, then apply the stimulus seen this cycle to the expectation queue
  always @(negedge clk_i) begin
    if (instr_valid_o && instr_ready_i) begin
      pops++;
      if (exp_q.size() == 0) chk("extra_pop", 64'(instr_pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        chk("pop_pc", 64'(instr_pc_o), 64'(exp_q[0].pc));
        chk("pop_ins", 64'(instr_o), 64'(exp_q[0].ins));
        chk("pop_fault", 64'(instr_fault_o), 64'(exp_q[0].f));
        void'(exp_q.pop_front());
      end
    end
    if (!rst_ni) push_stream(RV);
    else if (redirect_i) begin
      if (redirect_pc_i[1:0] != 2'b00) push_fault(redirect_pc_i);
      else push_stream(redirect_pc_i);
    end
  end
  task automatic drv;
    @(posedge clk_i);
    #1;
  endtask
  task automatic smp;
    @(negedge clk_i);
    #1;
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(instr_valid_o), 64'(0));
    chk({tag, "_ins"}, 64'(instr_o), 64'(0));
    chk({tag, "_pc"}, 64'(instr_pc_o), 64'(0));
    chk({tag, "_fault"}, 64'(instr_fault_o), 64'(0));
    chk({tag, "_addr"}, 64'(mem_addr_o), 64'(RV));
  endtask
  task automatic redirect_to(input logic [31:0] tgt);
    drv;
    redirect_i = 1'b1;
    redirect_pc_i = tgt;
    instr_ready_i = 1'b1;
    drv;
    redirect_i = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst_ni = 1'b0;
    instr_ready_i = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    repeat (3) @(posedge clk_i);
    smp;
    check_reset_vals("rst");
    drv;
    rst_ni = 1'b1;
    @(posedge clk_i);
    smp;
    chk("first_valid", 64'(instr_valid_o), 64'(1));
    chk("first_pc", 64'(instr_pc_o), 64'(RV));
    chk("first_ins", 64'(instr_o), 64'(RV ^ PAT));
    p0 = pops;
    repeat (8) smp;
    chk("thru_8", 64'(pops - p0), 64'(8));
    drv;
    instr_ready_i = 1'b0;
    p0 = pops;
    repeat (10) smp;
    chk("bp_nopop", 64'(pops - p0), 64'(0));
    chk("bp_valid", 64'(instr_valid_o), 64'(1));
    chk("bp_head", 64'(instr_pc_o), 64'(exp_q[0].pc));
    chk("bp_addr", 64'(mem_addr_o), 64'(exp_q[0].pc + 32'd16));
    drv;
    instr_ready_i = 1'b1;
    p0 = pops;
    repeat (6) smp;
    chk("bp_drain", 64'(pops - p0), 64'(6));
    drv;
    instr_ready_i = 1'b0;
    repeat (6) drv;
    redirect_to(32'h0000_0100);
    smp;
    chk("rd_bubble", 64'(instr_valid_o), 64'(0));
    smp;
    chk("rd_valid", 64'(instr_valid_o), 64'(1));
    chk("rd_pc", 64'(instr_pc_o), 64'h100);
    repeat (4) smp;
    redirect_to(32'h0000_0102);
    smp;
    chk("mis_valid", 64'(instr_valid_o), 64'(1));
    chk("mis_fault", 64'(instr_fault_o), 64'(1));
    chk("mis_pc", 64'(instr_pc_o), 64'h102);
    chk("mis_ins", 64'(instr_o), 64'(0));
    repeat (20) smp;
    chk("halt_valid", 64'(instr_valid_o), 64'(0));
    chk("halt_addr", 64'(mem_addr_o), 64'h102);
    chk("halt_left", 64'(exp_q.size()), 64'(0));
    redirect_to(32'h0000_0200);
    smp;
    p0 = pops;
    repeat (6) smp;
    chk("resume_pops", 64'(pops - p0), 64'(6));
    redirect_to(32'hFFFF_FFF8);
    smp;
    smp;
    chk("wrap0", 64'(instr_pc_o), 64'hFFFF_FFF8);
    smp;
    chk("wrap1", 64'(instr_pc_o), 64'hFFFF_FFFC);
    smp;
    chk("wrap2", 64'(instr_pc_o), 64'h0000_0000);
    smp;
    chk("wrap3", 64'(instr_pc_o), 64'h0000_0004);
    repeat (3) smp;
    drv;
    rst_ni = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0300;
    drv;
    rst_ni = 1'b1;
    redirect_i = 1'b0;
    smp;
    check_reset_vals("mid_rst");
    smp;
    chk("restart_valid", 64'(instr_valid_o), 64'(1));
    chk("restart_pc", 64'(instr_pc_o), 64'(RV));
    p0 = pops;
    repeat (5) smp;
    chk("restart_pops", 64'(pops - p0), 64'(5));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the nona core. It owns the program counter and drives a combinational-read instruction memory (async ROM). Fetched words go into a small in-order instruction queue with a valid/ready handshake toward decode. It supports PC redirection with queue flush and flags misaligned redirect targets.

## Interface
- XLen, nona_pkg::XLen (32): address/PC width.
- ResetVector, nona_pkg::ResetVector: PC value loaded in reset; must be 4-byte aligned.
- QueueDepth, 4: instruction queue entries; power of two, ≥2.
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  synchronous active-low reset, sampled on clk_i rising edge.
- mem_addr_o  out  XLen  fetch address to instruction memory; always equals pc_q.
- mem_rdata_i  in  32  instruction word at mem_addr_o, same-cycle (combinational) response.
- redirect_i  in  1  single-cycle request to restart fetch at redirect_pc_i.
- redirect_pc_i  in  XLen  redirect target.
- instr_valid_o  out  1  queue head holds a valid entry.
- instr_ready_i  in  1  consumer accepts head this cycle.
- instr_o  out  32  head instruction word.
- instr_pc_o  out  XLen  PC of head instruction.
- instr_fault_o  out  1  head entry is a misaligned-fetch fault marker; instr_o = 0 for such entries.

## Operation
- State: pc_q, halted_q, circular queue (storage, rd_ptr, wr_ptr, count of clog2(QueueDepth)+1 bits).
- pop = instr_valid_o & instr_ready_i. Handshake rule: the head stays stable while valid and not popped.
- Normal fetch, with redirect_i=0 and halted_q=0: push = (count < QueueDepth) | pop. On push, write {pc_q, mem_rdata_i, fault=0} and set pc_q <= pc_q + 4.
- PC arithmetic is modulo 2^XLen: 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no flag.
- When the queue is full and there is no pop, there is no push, pc_q holds, and mem_addr_o is unchanged.
- Redirect (redirect_i=1) has priority over push and pop:
  - All entries are discarded: count <= 0, rd_ptr = wr_ptr. A concurrent pop is still considered consumed by the sender but has no further effect.
  - No push occurs that cycle.
  - If redirect_pc_i[1:0]==0: pc_q <= redirect_pc_i and halted_q <= 0.
  - Otherwise: enqueue exactly one entry {redirect_pc_i, 32'h0, fault=1} into the now-empty queue, set halted_q <= 1, and leave pc_q <= redirect_pc_i.
- Halted (halted_q=1): no pushes. The queue drains normally, and only a new redirect clears the halt.
- Memory is sampled only in the cycle a push occurs; mem_rdata_i is ignored otherwise.

## Timing
- Reset values: pc_q = ResetVector, mem_addr_o = ResetVector, count = 0, pointers = 0, halted_q = 0, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0, instr_fault_o = 0. Queue storage is cleared to zero.
- Reset asserted mid-operation overrides redirect, push and pop in that cycle.
- Latency: a word pushed at edge N is visible at the head after edge N when the queue was empty, i.e. first valid instruction the cycle after reset release.
- Redirect applied at edge N: instr_valid_o = 0 for the cycle after N (aligned target), and the first target instruction is valid after edge N+1.
- Misaligned redirect: the fault entry is valid in the cycle right after edge N.
- Sustained throughput is one instruction per cycle whenever instr_ready_i stays high.
- All outputs are registered or pure functions of registered state. There is no combinational path from instr_ready_i or redirect_i to any output.

## Test plan
- Reset release with ready=1 and memory returning addr^0xA5A5_A5A5. The required stream is PCs ResetVector, +4, +8, ..., one per cycle, each instr_o matching its memory word.
- Backpressure: hold ready=0 for 10 cycles.
  - count must saturate at 4 with PCs RV..RV+12 queued.
  - mem_addr_o must hold at RV+16.
  - When ready returns to 1, all words must come out in order with no loss or duplication.
- Redirect to 0x0000_0100 while the queue is full and pop=1.
  - The queue must flush and the next valid entry must be PC 0x100 after one bubble.
  - No stale entry may appear.
- Misaligned redirect to 0x0000_0102. The bench must see exactly one entry with instr_fault_o=1, instr_pc_o=0x102 and instr_o=0, then valid=0 indefinitely. A later redirect to 0x200 must resume fetch.
- Wrap-around: redirect to 0xFFFF_FFF8. The required PC sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert rst_ni=0 for one cycle mid-stream with a concurrent redirect. Every output must return to its reset value and fetch must restart at ResetVector.
